serial_add_sub: RTL and testbench
=================================

# serial_add_sub

Parametrised bit-serial adder/subtractor: it processes one bit per clock through a single full-adder cell built from two half-adder stages and a carry flip-flop. An operation is started with a one-cycle `start` strobe and produces a registered `WIDTH`-bit result with carry and signed overflow. The block is the multi-bit, multi-mode successor to the team's combinational half-adder. It sits between board switch/button inputs (debounced upstream) and LED/seven-segment display logic on the Mimas V2.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request strobe; sampled only in IDLE.
- `sub`  in  1  mode, sampled with `start`: 0 = a+b, 1 = a−b.
- `a`  in  WIDTH  operand A, sampled with `start`.
- `b`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  registered result.
- `cout`  out  1  carry out. In add mode it is the unsigned carry. In sub mode it is 1 when a ≥ b unsigned (no borrow).
- `ovf`  out  1  signed two's-complement overflow.

## Operation
- State machine has three states: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1 at a clock edge. At that edge:
  - `a` is loaded into shift register A.
  - `b` (or ~`b` when `sub`=1) is loaded into shift register B.
  - The carry flip-flop is loaded with `sub`.
  - The bit counter is cleared to 0.
- RUN, at each edge:
  - Bit sum: s = A[0]^B[0]^c.
  - Carry: c' = (A[0]&B[0]) | (c&(A[0]^B[0])).
  - s is shifted into the MSB of the result shift register. A and B shift right by one.
  - The counter increments.
- RUN → DONE at the edge that processes bit WIDTH−1. At that same edge:
  - `sum` is loaded with the assembled result.
  - `cout` is loaded with the final carry.
  - `ovf` is loaded with (carry into MSB) XOR (carry out of MSB). The carry into the MSB is the carry flip-flop value before that edge.
- DONE → IDLE unconditionally on the next edge.
- `start` in RUN or DONE is ignored: no queueing, no restart.
- `sum`, `cout` and `ovf` change only at the RUN→DONE edge. They hold their values through IDLE until the next completion.
- `a`, `b` and `sub` may change freely after the accepting edge without affecting the result.
- The counter is `$clog2(WIDTH)` bits wide and never wraps within an operation.

## Timing
- Reset: on any edge with `rst_n`=0, all of the following are cleared, regardless of state:
  - state = IDLE;
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0;
  - shift registers, carry and counter = 0.
- Reset mid-operation aborts the operation with no `done`.
- If `rst_n`=0 and `start`=1 on the same edge, reset wins.
- Latency: take edge E0 as the edge that accepts `start`.
  - `busy` is high after E0.
  - Bits are processed at E1..E_WIDTH.
  - `done`=1 and the result is valid in the cycle after E_WIDTH.
  - E_WIDTH+1 returns the block to IDLE: `busy`=0, `done`=0.
- Throughput: one operation per WIDTH+2 cycles. The earliest next `start` is accepted at E_WIDTH+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then WIDTH=8, a=0x0F, b=0x01, sub=0, `start` at E0:
  - `busy` is high from E0.
  - `done` pulses exactly one cycle after E8.
  - Result: `sum`=0x10, `cout`=0, `ovf`=0.
- Add boundary cases:
  - a=0xFF, b=0x01 → `sum`=0x00, `cout`=1, `ovf`=0.
  - a=0x7F, b=0x01 → `sum`=0x80, `cout`=0, `ovf`=1.
- Subtract cases:
  - a=0x05, b=0x07, sub=1 → `sum`=0xFE, `cout`=0, `ovf`=0.
  - a=0x80, b=0x01, sub=1 → `sum`=0x7F, `cout`=1, `ovf`=1.
- `start` pulses at E3 and at the DONE cycle while the a=0x0F, b=0x01 operation is running:
  - Both pulses are ignored; only one `done` occurs; `sum`=0x10.
  - A `start` at E10 is accepted.
  - Changing `a`/`b` mid-RUN has no effect on the result.
- `rst_n`=0 at E4 of an operation:
  - The next cycle shows IDLE with `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - No `done` pulse follows.
  - A fresh `start` afterwards completes normally.
- WIDTH=2 and WIDTH=32 builds:
  - 32-bit 0xFFFFFFFF+0x00000001 → `sum`=0, `cout`=1, `done` after 32 bit edges.
  - 2-bit 0b01−0b10 → `sum`=0b11, `cout`=0, `ovf`=1.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop walks the
// operands LSB first and delivers a registered result with carry and overflow.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int RES_W = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sh_a, sh_b;
  logic [RES_W-1:0]   sh_res;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               bit_s, bit_c;

  // Full adder as two cascaded half adders; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic p, g;
    p = x ^ y;
    g = x & y;
    return {g | (p & ci), p ^ ci};
  endfunction

  assign {bit_c, bit_s} = full_add(sh_a[0], sh_b[0], carry);
  assign last_bit       = (cnt == CNT_W'(WIDTH - 1));
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sh_res <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 rides in on the carry flop.
            sh_a  <= a;
            sh_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
          sh_res <= (sh_res >> 1) | (RES_W'(bit_s) << (RES_W - 1));
          carry  <= bit_c;
          if (last_bit) begin
            // carry still holds the carry into the MSB at this edge.
            sum  <= {bit_s, sh_res};
            cout <= bit_c;
            ovf  <= carry ^ bit_c;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: 2-, 8- and 32-bit instances checked
// against a scoreboard filled from an arithmetic reference model.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start2, sub2, busy2, done2, cout2, ovf2;
  logic [1:0]  a2, b2, sum2;
  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start32, sub32, busy32, done32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  serial_add_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_add_sub #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt8 = 0;

  always @(posedge clk) if (done8) done_cnt8++;

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic sub);
    longint one, mask, au, bu, xa, xb, r, full;
    exp_t e;
    one  = 1;
    mask = (one << w) - 1;
    au   = longint'(a) & mask;
    bu   = longint'(b) & mask;
    xa   = (au >= (one << (w - 1))) ? au - (one << w) : au;
    xb   = (bu >= (one << (w - 1))) ? bu - (one << w) : bu;
    if (!sub) begin
      full   = au + bu;
      e.sum  = 32'(full & mask);
      e.cout = (full >= (one << w));
      r      = xa + xb;
    end else begin
      full   = au - bu;
      e.sum  = 32'(full & mask);
      e.cout = (au >= bu);
      r      = xa - xb;
    end
    e.ovf = (r > (one << (w - 1)) - 1) || (r < -(one << (w - 1)));
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int w, logic [31:0] a, logic [31:0] b, logic sub, logic st);
    case (w)
      2:  begin a2 = a[1:0]; b2 = b[1:0]; sub2 = sub; start2 = st; end
      8:  begin a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; start8 = st; end
      default: begin a32 = a; b32 = b; sub32 = sub; start32 = st; end
    endcase
  endtask

  task automatic sample(int w, output logic busy, output logic dn,
                        output logic [31:0] s, output logic c, output logic o);
    case (w)
      2:  begin busy = busy2; dn = done2; s = 32'(sum2); c = cout2; o = ovf2; end
      8:  begin busy = busy8; dn = done8; s = 32'(sum8); c = cout8; o = ovf8; end
      default: begin busy = busy32; dn = done32; s = sum32; c = cout32; o = ovf32; end
    endcase
  endtask

  // Runs one operation; expected result goes to the scoreboard at the start
  // edge. Operands are scrambled right after acceptance.
  task automatic do_op(int w, logic [31:0] a, logic [31:0] b, logic sub,
                       output logic [31:0] s, output logic c, output logic o,
                       output int lat, output logic busy0, output logic idle_after);
    logic bz, dn;
    sb.push_back(model(w, a, b, sub));
    drive(w, a, b, sub, 1'b1);
    tick();
    drive(w, ~a, ~b, ~sub, 1'b0);
    sample(w, busy0, dn, s, c, o);
    lat = 0;
    for (int i = 0; i < w + 8; i++) begin
      sample(w, bz, dn, s, c, o);
      if (dn) break;
      tick();
      lat++;
    end
    tick();
    sample(w, bz, dn, s, c, o);
    idle_after = !bz && !dn;
    sample(w, bz, dn, s, c, o);
  endtask

  task automatic test_reset();
    logic bz, dn, c, o;
    logic [31:0] s;
    rst_n = 1'b0;
    drive(2, 0, 0, 0, 1'b1);
    drive(8, 8'h0F, 8'h01, 0, 1'b1);
    drive(32, 0, 0, 0, 1'b1);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      int w;
      w = (k == 0) ? 2 : (k == 1) ? 8 : 32;
      sample(w, bz, dn, s, c, o);
      n_checks++;
      if ({bz, dn, s, c, o} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_w%0d: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                 w, bz, dn, s, c, o);
      end
    end
    drive(2, 0, 0, 0, 1'b0);
    drive(8, 0, 0, 0, 1'b0);
    drive(32, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_dropped: busy=%b, required 0", busy8);
    end
  endtask

  task automatic test_add_sub_cases();
    logic [31:0] tbl_a[5] = '{32'h0F, 32'hFF, 32'h7F, 32'h05, 32'h80};
    logic [31:0] tbl_b[5] = '{32'h01, 32'h01, 32'h01, 32'h07, 32'h01};
    logic        tbl_s[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] s;
    logic c, o, busy0, idle_after;
    int lat;
    exp_t e;
    for (int i = 0; i < 17; i++) begin
      logic [31:0] ta, tb;
      logic ts;
      if (i < 5) begin ta = tbl_a[i]; tb = tbl_b[i]; ts = tbl_s[i]; end
      else begin ta = $urandom_range(255); tb = $urandom_range(255); ts = $urandom_range(1); end
      do_op(8, ta, tb, ts, s, c, o, lat, busy0, idle_after);
      e = sb.pop_front();
      n_checks++;
      if ({s[7:0], c, o} !== {e.sum[7:0], e.cout, e.ovf}) begin
        n_fail++;
        $display("FAIL op8 %h%s%h: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 ta[7:0], ts ? "-" : "+", tb[7:0], s[7:0], c, o, e.sum[7:0], e.cout, e.ovf);
      end
      n_checks++;
      if (lat !== 8) begin
        n_fail++;
        $display("FAIL latency8 case %0d: done after %0d edges, required 8", i, lat);
      end
      n_checks++;
      if ({busy0, idle_after} !== 2'b11) begin
        n_fail++;
        $display("FAIL busy_window8 case %0d: busy_at_E0=%b idle_after_done=%b, required 1 1",
                 i, busy0, idle_after);
      end
    end
  endtask

  task automatic test_ignore_start();
    int d0;
    exp_t e;
    d0 = done_cnt8;
    sb.push_back(model(8, 32'h0F, 32'h01, 1'b0));
    drive(8, 32'h0F, 32'h01, 1'b0, 1'b1);
    tick();                                    // E0
    drive(8, 32'hAA, 32'h55, 1'b1, 1'b0);
    tick(); tick();                            // E1, E2
    drive(8, 32'hC3, 32'h3C, 1'b1, 1'b1);
    tick();                                    // E3: ignored
    drive(8, 32'h33, 32'h44, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();        // E4..E8
    n_checks++;
    if (done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_done_cycle: done=%b, required 1", done8);
    end
    e = sb.pop_front();
    n_checks++;
    if ({sum8, cout8, ovf8} !== {e.sum[7:0], e.cout, e.ovf}) begin
      n_fail++;
      $display("FAIL ignore_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
    end
    drive(8, 32'h11, 32'h22, 1'b0, 1'b1);
    tick();                                    // E9: start in DONE ignored
    drive(8, 32'h20, 32'h03, 1'b1, 1'b0);
    n_checks++;
    if ({busy8, done8} !== 2'b00) begin
      n_fail++;
      $display("FAIL ignore_idle_E9: busy=%b done=%b, required 0 0", busy8, done8);
    end
    n_checks++;
    if (done_cnt8 - d0 !== 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: %0d pulses, required 1", done_cnt8 - d0);
    end
    sb.push_back(model(8, 32'h20, 32'h03, 1'b1));
    drive(8, 32'h20, 32'h03, 1'b1, 1'b1);
    tick();                                    // E10: accepted
    drive(8, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_E10: busy=%b, required 1", busy8);
    end
    for (int i = 0; i < 20 && !done8; i++) tick();
    e = sb.pop_front();
    n_checks++;
    if ({done8, sum8, cout8, ovf8} !== {1'b1, e.sum[7:0], e.cout, e.ovf}) begin
      n_fail++;
      $display("FAIL accept_E10_result: done=%b sum=%h cout=%b ovf=%b, required done=1 sum=%h cout=%b ovf=%b",
               done8, sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int d0;
    logic [31:0] s;
    logic c, o, busy0, idle_after;
    int lat;
    exp_t e;
    d0 = done_cnt8;
    drive(8, 32'h12, 32'h34, 1'b0, 1'b1);
    tick();                                    // E0
    drive(8, 32'h12, 32'h34, 1'b0, 1'b0);
    tick(); tick(); tick();                    // E1..E3
    rst_n = 1'b0;
    tick();                                    // E4
    rst_n = 1'b1;
    n_checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (done_cnt8 !== d0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: %0d pulses, required 0", done_cnt8 - d0);
    end
    do_op(8, 32'h12, 32'h34, 1'b0, s, c, o, lat, busy0, idle_after);
    e = sb.pop_front();
    n_checks++;
    if ({s[7:0], c, o, lat} !== {e.sum[7:0], e.cout, e.ovf, 32'd8}) begin
      n_fail++;
      $display("FAIL reset_mid_restart: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=8",
               s[7:0], c, o, lat, e.sum[7:0], e.cout, e.ovf);
    end
  endtask

  task automatic test_width2();
    logic [31:0] s;
    logic c, o, busy0, idle_after;
    int lat;
    exp_t e;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int m = 0; m < 2; m++) begin
          do_op(2, 32'(x), 32'(y), m[0], s, c, o, lat, busy0, idle_after);
          e = sb.pop_front();
          n_checks++;
          if ({s[1:0], c, o, lat, idle_after} !== {e.sum[1:0], e.cout, e.ovf, 32'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL op2 %0d%s%0d: sum=%b cout=%b ovf=%b lat=%0d, required sum=%b cout=%b ovf=%b lat=2",
                     x, m ? "-" : "+", y, s[1:0], c, o, lat, e.sum[1:0], e.cout, e.ovf);
          end
        end
  endtask

  task automatic test_width32();
    logic [31:0] s;
    logic c, o, busy0, idle_after;
    int lat;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ta, tb;
      logic ts;
      if (i == 0) begin ta = 32'hFFFF_FFFF; tb = 32'h1; ts = 1'b0; end
      else begin ta = $urandom; tb = $urandom; ts = i[0]; end
      do_op(32, ta, tb, ts, s, c, o, lat, busy0, idle_after);
      e = sb.pop_front();
      n_checks++;
      if ({s, c, o, lat} !== {e.sum, e.cout, e.ovf, 32'd32}) begin
        n_fail++;
        $display("FAIL op32 %h%s%h: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=32",
                 ta, ts ? "-" : "+", tb, s, c, o, lat, e.sum, e.cout, e.ovf);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2, 0, 0, 0, 1'b0);
    drive(8, 0, 0, 0, 1'b0);
    drive(32, 0, 0, 0, 1'b0);
    test_reset();
    test_add_sub_cases();
    test_ignore_start();
    test_reset_mid_op();
    test_width2();
    test_width32();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
